// File: rtl/mem_wb_stage.sv
// MEM pipeline stage and MEM/WB register: data-memory handshake, store/load alignment,
// pipeline stall generation and the registers feeding writeback.
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] MEM_pc,
    input  logic [2:0]      MEM_funct3,
    input  logic [XLEN-1:0] MEM_alu_out,
    input  logic [XLEN-1:0] MEM_rs2,
    input  logic            MEM_cmp_out,
    input  logic [XLEN-1:0] MEM_u_imm,
    input  logic [SELW-1:0] MEM_regfilemux_sel,
    input  logic [4:0]      MEM_rd,
    input  logic            MEM_load_regfile,
    input  logic            MEM_mem_read,
    input  logic            MEM_mem_write,
    input  logic            stall_in,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_address,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_byte_enable,
    output logic            mem_stall,
    output logic [XLEN-1:0] WB_pc,
    output logic [2:0]      WB_funct3,
    output logic [XLEN-1:0] WB_rdata,
    output logic            WB_cmp_out,
    output logic [XLEN-1:0] WB_alu_out,
    output logic [XLEN-1:0] WB_u_imm,
    output logic [SELW-1:0] WB_regfilemux_sel,
    output logic [4:0]      WB_rd,
    output logic            WB_load_regfile
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_HELD = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_hold;
    logic [1:0]      w_offset;
    logic            w_is_read;
    logic            w_is_write;
    logic            w_mem_op;
    logic            w_advance;
    logic [3:0]      w_mask;
    logic [XLEN-1:0] w_rdata_src;
    logic [XLEN-1:0] w_rdata_aligned;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // A load wins when both read and write are (illegally) set.
    assign w_offset   = MEM_alu_out[1:0];
    assign w_is_read  = MEM_mem_read;
    assign w_is_write = MEM_mem_write & ~MEM_mem_read;
    assign w_mem_op   = w_is_read | w_is_write;
    assign w_mask     = size_mask(MEM_funct3[1:0]) << w_offset;

    assign dmem_address     = {MEM_alu_out[XLEN-1:2], 2'b00};
    assign dmem_wdata       = MEM_rs2 << {w_offset, 3'b000};
    assign dmem_byte_enable = w_is_write ? w_mask : (w_is_read ? 4'b1111 : 4'b0000);

    assign w_rdata_src     = (r_state == S_HELD) ? r_hold : dmem_rdata;
    assign w_rdata_aligned = w_rdata_src >> {w_offset, 3'b000};
    assign w_advance       = ~mem_stall & ~stall_in;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !stall_in) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (dmem_resp) begin
                    w_state_nxt = stall_in ? S_HELD : S_IDLE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_HELD: begin
                if (!stall_in) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HELD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: request strobes and pipeline stall
    always_comb begin
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && w_mem_op) begin
                    mem_stall  = 1'b1;
                    dmem_read  = w_is_read & ~stall_in;
                    dmem_write = w_is_write & ~stall_in;
                end else begin
                    mem_stall  = 1'b0;
                end
            end
            S_BUSY: begin
                dmem_read  = w_is_read;
                dmem_write = w_is_write;
                mem_stall  = ~dmem_resp;
            end
            S_HELD: begin
                mem_stall  = 1'b0;
            end
            default: begin
                mem_stall  = 1'b0;
            end
        endcase
    end

    // Capture read data that arrives while the pipeline is frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= {XLEN{1'b0}};
        end else if (r_state == S_BUSY && dmem_resp && stall_in) begin
            r_hold <= dmem_rdata;
        end else begin
            r_hold <= r_hold;
        end
    end

    // MEM/WB register: load on advance, bubble while MEM stalls, hold under global freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_pc             <= {XLEN{1'b0}};
            WB_funct3         <= 3'b000;
            WB_rdata          <= {XLEN{1'b0}};
            WB_cmp_out        <= 1'b0;
            WB_alu_out        <= {XLEN{1'b0}};
            WB_u_imm          <= {XLEN{1'b0}};
            WB_regfilemux_sel <= {SELW{1'b0}};
            WB_rd             <= 5'd0;
            WB_load_regfile   <= 1'b0;
        end else if (w_advance) begin
            WB_pc             <= MEM_pc;
            WB_funct3         <= MEM_funct3;
            WB_rdata          <= w_is_read ? w_rdata_aligned : {XLEN{1'b0}};
            WB_cmp_out        <= MEM_cmp_out;
            WB_alu_out        <= MEM_alu_out;
            WB_u_imm          <= MEM_u_imm;
            WB_regfilemux_sel <= MEM_regfilemux_sel;
            WB_rd             <= MEM_rd;
            WB_load_regfile   <= MEM_load_regfile;
        end else if (mem_stall && !stall_in) begin
            WB_load_regfile   <= 1'b0;
        end else begin
            WB_load_regfile   <= WB_load_regfile;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected MEM/WB contents are queued when an
// instruction is driven and popped when it reaches the WB register.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MEM_pc, MEM_alu_out, MEM_rs2, MEM_u_imm;
    logic [2:0]  MEM_funct3;
    logic        MEM_cmp_out, MEM_load_regfile, MEM_mem_read, MEM_mem_write;
    logic [3:0]  MEM_regfilemux_sel;
    logic [4:0]  MEM_rd;
    logic        stall_in, dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read, dmem_write, mem_stall;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] WB_pc, WB_rdata, WB_alu_out, WB_u_imm;
    logic [2:0]  WB_funct3;
    logic        WB_cmp_out, WB_load_regfile;
    logic [3:0]  WB_regfilemux_sel;
    logic [4:0]  WB_rd;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        cmp;
        logic [31:0] alu;
        logic [31:0] uimm;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        ld;
    } wb_t;

    wb_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  rd_cnt, st_cnt;

    mem_wb_stage #(.XLEN(32), .SELW(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_pc(MEM_pc), .MEM_funct3(MEM_funct3), .MEM_alu_out(MEM_alu_out),
        .MEM_rs2(MEM_rs2), .MEM_cmp_out(MEM_cmp_out), .MEM_u_imm(MEM_u_imm),
        .MEM_regfilemux_sel(MEM_regfilemux_sel), .MEM_rd(MEM_rd),
        .MEM_load_regfile(MEM_load_regfile), .MEM_mem_read(MEM_mem_read),
        .MEM_mem_write(MEM_mem_write), .stall_in(stall_in),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .mem_stall(mem_stall),
        .WB_pc(WB_pc), .WB_funct3(WB_funct3), .WB_rdata(WB_rdata),
        .WB_cmp_out(WB_cmp_out), .WB_alu_out(WB_alu_out), .WB_u_imm(WB_u_imm),
        .WB_regfilemux_sel(WB_regfilemux_sel), .WB_rd(WB_rd),
        .WB_load_regfile(WB_load_regfile)
    );

    always #5 clk = ~clk;

    // Cycle budget so the run always ends
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 5000) begin
            $display("FAIL watchdog cycle budget exhausted");
            $fatal(1, "watchdog");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic cmp, input logic [31:0] uimm,
                         input logic [3:0] sel, input logic [4:0] rd, input logic ld,
                         input logic rq, input logic wq);
        MEM_pc = pc; MEM_funct3 = f3; MEM_alu_out = alu; MEM_rs2 = rs2;
        MEM_cmp_out = cmp; MEM_u_imm = uimm; MEM_regfilemux_sel = sel; MEM_rd = rd;
        MEM_load_regfile = ld; MEM_mem_read = rq; MEM_mem_write = wq;
    endtask

    task automatic push_exp(input logic [31:0] exp_rdata);
        wb_t e;
        e.pc = MEM_pc; e.f3 = MEM_funct3; e.rdata = exp_rdata; e.cmp = MEM_cmp_out;
        e.alu = MEM_alu_out; e.uimm = MEM_u_imm; e.sel = MEM_regfilemux_sel;
        e.rd = MEM_rd; e.ld = MEM_load_regfile;
        sb.push_back(e);
    endtask

    task automatic expect_wb();
        wb_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("WB_pc", WB_pc, e.pc);
            chk("WB_funct3", {29'd0, WB_funct3}, {29'd0, e.f3});
            chk("WB_rdata", WB_rdata, e.rdata);
            chk("WB_cmp_out", {31'd0, WB_cmp_out}, {31'd0, e.cmp});
            chk("WB_alu_out", WB_alu_out, e.alu);
            chk("WB_u_imm", WB_u_imm, e.uimm);
            chk("WB_sel", {28'd0, WB_regfilemux_sel}, {28'd0, e.sel});
            chk("WB_rd", {27'd0, WB_rd}, {27'd0, e.rd});
            chk("WB_load_regfile", {31'd0, WB_load_regfile}, {31'd0, e.ld});
        end
    endtask

    initial begin
        // Reset with a load presented: nothing may be requested
        rst = 1'b1; stall_in = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'h0;
        drive(32'h10, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, 4'h1, 5'd1, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk("rst_WB_pc", WB_pc, 32'h0);
        chk("rst_WB_alu_out", WB_alu_out, 32'h0);
        chk("rst_WB_rdata", WB_rdata, 32'h0);
        chk("rst_WB_load_regfile", {31'd0, WB_load_regfile}, 32'h0);
        chk("rst_dmem_read", {31'd0, dmem_read}, 32'h0);
        chk("rst_dmem_write", {31'd0, dmem_write}, 32'h0);
        chk("rst_mem_stall", {31'd0, mem_stall}, 32'h0);

        // Two back-to-back ALU ops pass straight through
        rst = 1'b0;
        drive(32'h40, 3'b000, 32'h12345678, 32'h0, 1'b1, 32'hABCDE000, 4'h2, 5'd3, 1'b1, 1'b0, 1'b0);
        push_exp(32'h0);
        #1;
        chk("alu_no_stall", {31'd0, mem_stall}, 32'h0);
        chk("alu_no_read", {31'd0, dmem_read}, 32'h0);
        tick(); expect_wb();
        drive(32'h44, 3'b111, 32'hFFFF0001, 32'h0, 1'b0, 32'h00001000, 4'hF, 5'd4, 1'b1, 1'b0, 1'b0);
        push_exp(32'h0);
        tick(); expect_wb();

        // LW 0x100, response in the third request cycle
        drive(32'h80, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, 4'h1, 5'd5, 1'b1, 1'b1, 1'b0);
        push_exp(32'hDEADBEEF);
        rd_cnt = 0; st_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            dmem_resp  = (i == 2);
            dmem_rdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (dmem_read) rd_cnt++;
            if (mem_stall) st_cnt++;
            if (i == 0) begin
                chk("lw_addr", dmem_address, 32'h100);
                chk("lw_be", {28'd0, dmem_byte_enable}, 32'hF);
            end else begin
                chk("lw_bubble", {31'd0, WB_load_regfile}, 32'h0);
            end
            tick();
        end
        dmem_resp = 1'b0;
        chk("lw_read_cycles", rd_cnt, 32'd3);
        chk("lw_stall_cycles", st_cnt, 32'd2);
        expect_wb();

        // LBU 0x103 at minimum latency
        drive(32'h84, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0, 4'h1, 5'd6, 1'b1, 1'b1, 1'b0);
        push_exp(32'h000000AA);
        #1;
        chk("lbu_addr", dmem_address, 32'h100);
        chk("lbu_be", {28'd0, dmem_byte_enable}, 32'hF);
        chk("lbu_read", {31'd0, dmem_read}, 32'h1);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'hAABBCCDD;
        #1;
        chk("lbu_resp_no_stall", {31'd0, mem_stall}, 32'h0);
        tick();
        dmem_resp = 1'b0;
        expect_wb();

        // SH 0x202
        drive(32'h88, 3'b001, 32'h202, 32'h00001234, 1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        push_exp(32'h0);
        #1;
        chk("sh_write", {31'd0, dmem_write}, 32'h1);
        chk("sh_read", {31'd0, dmem_read}, 32'h0);
        chk("sh_wdata", dmem_wdata, 32'h12340000);
        chk("sh_be", {28'd0, dmem_byte_enable}, 32'hC);
        chk("sh_addr", dmem_address, 32'h200);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h55555555;
        tick();
        dmem_resp = 1'b0;
        expect_wb();

        // Misaligned SH at offset 3: mask truncated
        drive(32'h8C, 3'b001, 32'h307, 32'h0000BEEF, 1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        push_exp(32'h0);
        #1;
        chk("sh3_be", {28'd0, dmem_byte_enable}, 32'h8);
        chk("sh3_wdata", dmem_wdata, 32'hEF000000);
        chk("sh3_addr", dmem_address, 32'h304);
        tick();
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        expect_wb();

        // Read and write both set: treated as a load
        drive(32'h90, 3'b010, 32'h410, 32'h99, 1'b1, 32'h0, 4'h1, 5'd8, 1'b1, 1'b1, 1'b1);
        push_exp(32'h0BADF00D);
        #1;
        chk("rw_read", {31'd0, dmem_read}, 32'h1);
        chk("rw_write", {31'd0, dmem_write}, 32'h0);
        chk("rw_be", {28'd0, dmem_byte_enable}, 32'hF);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h0BADF00D;
        tick();
        dmem_resp = 1'b0;
        expect_wb();

        // LW under global freeze: no request while frozen, then HELD data
        drive(32'h94, 3'b010, 32'h400, 32'h0, 1'b0, 32'h0, 4'h1, 5'd7, 1'b1, 1'b1, 1'b0);
        push_exp(32'h11223344);
        stall_in = 1'b1;
        #1;
        chk("frz_no_req", {31'd0, dmem_read}, 32'h0);
        chk("frz_stall", {31'd0, mem_stall}, 32'h1);
        tick();
        stall_in = 1'b0;
        #1;
        chk("frz_req", {31'd0, dmem_read}, 32'h1);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 32'h11223344; stall_in = 1'b1;
        #1;
        chk("frz_resp_no_stall", {31'd0, mem_stall}, 32'h0);
        tick();
        dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("held_no_req", {31'd0, dmem_read}, 32'h0);
        chk("held_no_stall", {31'd0, mem_stall}, 32'h0);
        chk("held_wb_hold", {31'd0, WB_load_regfile}, 32'h0);
        tick();
        dmem_resp = 1'b0; stall_in = 1'b0;
        #1;
        chk("held_release_no_req", {31'd0, dmem_read}, 32'h0);
        tick();
        expect_wb();

        // Reset while BUSY drops the request; late response ignored
        drive(32'hA0, 3'b010, 32'h500, 32'h0, 1'b0, 32'h0, 4'h1, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        chk("rb_req", {31'd0, dmem_read}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("rb_busy_req", {31'd0, dmem_read}, 32'h1);
        tick();
        chk("rb_WB_pc", WB_pc, 32'h0);
        chk("rb_WB_ld", {31'd0, WB_load_regfile}, 32'h0);
        rst = 1'b0;
        drive(32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("rb_dropped_req", {31'd0, dmem_read}, 32'h0);
        chk("rb_no_stall", {31'd0, mem_stall}, 32'h0);
        tick();
        dmem_resp = 1'b0;
        chk("rb_late_rdata", WB_rdata, 32'h0);
        chk("rb_late_ld", {31'd0, WB_load_regfile}, 32'h0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
